wb_writer: RTL
==============

Name: wb_writer

Overview:
- Write-side driver for the register file's single write port (we/waddr/wdata).
- Accepts committed results from the MEM/WB stage over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains at most one write per cycle into the register file.
- Provides combinational forwarding lookups so ID can see values still queued and not yet written.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
DATA_W, 32, result width (matches RegBus)
ADDR_W, 5, register address width (matches RegAddrBus)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  result offered by MEM/WB
in_ready  out  1  block can accept this cycle
in_we  in  1  result targets a register
in_waddr  in  ADDR_W  destination register
in_wdata  in  DATA_W  result value
wb_hold  in  1  pipeline control blocks draining this cycle
we  out  1  register file write enable (registered)
waddr  out  ADDR_W  register file write address (registered)
wdata  out  DATA_W  register file write data (registered)
fwd_raddr1  in  ADDR_W  lookup address, operand 1
fwd_hit1  out  1  queued value exists for fwd_raddr1
fwd_data1  out  DATA_W  youngest queued value for fwd_raddr1
fwd_raddr2  in  ADDR_W  lookup address, operand 2
fwd_hit2  out  1  as above, operand 2
fwd_data2  out  DATA_W  as above, operand 2
pending  out  clog2(DEPTH)+1  valid FIFO entries
empty  out  1  pending == 0

Behaviour:
- Reset (rst=1 at edge): pointers=0, count=0, we=0, waddr=0, wdata=0. All entries invalid. Any in-flight handshake is discarded. in_ready=0 while rst=1.
- in_ready = !rst && (count != DEPTH). It is a function of state only, never of in_valid. A pop in the same cycle does not free a slot for a push.
- Accept: a transfer occurs when in_valid && in_ready at the edge.
  - If in_we=0 or in_waddr=0, the transfer completes but nothing is stored (x0 writes dropped).
  - Otherwise {waddr, wdata} is stored at the tail, tail increments mod DEPTH, count++.
- Drain: at the edge, if count != 0 and wb_hold=0:
  - head entry loads the output regs with we=1; head increments mod DEPTH; count--.
  - Otherwise we<=0, and waddr/wdata hold their last values.
  - we is therefore a one-cycle pulse per entry; back-to-back pulses occur when count stays > 0.
- Latency (no bypass): accepted at edge E, earliest we=1 in the cycle after edge E+1 (2 cycles). Strict FIFO order is preserved.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full: in_ready=0; the producer holds in_valid and its data stable.
- wb_hold=1 mid-stream: no pop, we=0 the following cycle, entries retained.
- Forwarding (combinational):
  - Search all valid FIFO entries, youngest first (tail-1 back to head).
  - Then search the output register if we=1.
  - First address match sets hit=1 and data=that entry's value.
  - raddr=0 never hits. No match: hit=0, data=0.
- Pointer wrap-around is transparent. The full/empty distinction comes from count, not pointer equality.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: when count==0, wb_hold=0 and a storable transfer is accepted, the input loads the output regs directly (we=1 the next cycle) without entering the FIFO. Latency is 1 cycle. A bypassed entry is never visible in pending.
- Not defined: every storable transfer goes through the FIFO; latency is always >= 2.

Test Plan:
- Reset check: assert rst for 2 cycles mid-stream with 3 entries queued -> next cycle we=0, waddr=0, wdata=0, pending=0, empty=1; in_ready=1 after rst drops.
- Single write: push (x5, 0x12345678), wb_hold=0 -> we=1, waddr=5, wdata=0x12345678 exactly one cycle, 2 cycles after accept (1 cycle with WB_BYPASS_EN).
- Fill and order: hold wb_hold=1, push x1..x4 values 0x11..0x44 -> in_ready=0, pending=4. Release hold -> four consecutive we pulses in order x1..x4.
- x0/no-write drop: push (x0, 0xDEAD) and (in_we=0, x7) -> both handshakes complete, pending stays 0, we never asserted.
- Forwarding priority: with wb_hold=1, push (x3, 0xA) then (x3, 0xB), fwd_raddr1=3, fwd_raddr2=0 -> fwd_hit1=1, fwd_data1=0xB, fwd_hit2=0.
- Wrap with concurrent push/pop: stream 10 entries with wb_hold toggling every 3 cycles -> all 10 written in order, none lost or duplicated, pending never exceeds 4.

Source files
------------

// File: rtl/wb_writer.sv
// Register-file write-port driver: buffers committed MEM/WB results in an in-order FIFO,
// drains one write per cycle and forwards queued values to ID. Optional macro WB_BYPASS_EN.
module wb_writer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_we,
  input  logic [ADDR_W-1:0]          in_waddr,
  input  logic [DATA_W-1:0]          in_wdata,
  input  logic                       wb_hold,
  output logic                       we,
  output logic [ADDR_W-1:0]          waddr,
  output logic [DATA_W-1:0]          wdata,
  input  logic [ADDR_W-1:0]          fwd_raddr1,
  output logic                       fwd_hit1,
  output logic [DATA_W-1:0]          fwd_data1,
  input  logic [ADDR_W-1:0]          fwd_raddr2,
  output logic                       fwd_hit2,
  output logic [DATA_W-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic full;
  logic accept;
  logic storable;
  logic push;
  logic pop;
  logic bypass;

  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = !rst && !full;
  assign accept   = in_valid && in_ready;
  // Writes to x0 or with in_we low complete the handshake but are never stored.
  assign storable = accept && in_we && (in_waddr != '0);
  assign pop      = (count != '0) && !wb_hold;

`ifdef WB_BYPASS_EN
  assign bypass = storable && (count == '0) && !wb_hold;
`else
  assign bypass = 1'b0;
`endif

  assign push    = storable && !bypass;
  assign pending = count;
  assign empty   = (count == '0);

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is defined solely by count.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{addr: in_waddr, data: in_wdata};
  end

  // Registered write port; address/data hold their last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (pop) begin
      we    <= 1'b1;
      waddr <= mem[head].addr;
      wdata <= mem[head].data;
    end else if (bypass) begin
      we    <= 1'b1;
      waddr <= in_waddr;
      wdata <= in_wdata;
    end else begin
      we    <= 1'b0;
    end
  end

  // Forwarding: output register is lowest priority, then FIFO entries oldest to youngest,
  // so the last match written wins and the youngest queued value is returned.
  logic [ADDR_W-1:0] raddr [2];
  logic              hit   [2];
  logic [DATA_W-1:0] hdata [2];
  logic [PTR_W-1:0]  idx;

  assign raddr[0] = fwd_raddr1;
  assign raddr[1] = fwd_raddr2;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    idx = head;
    for (int p = 0; p < 2; p++) begin
      hit[p]   = 1'b0;
      hdata[p] = '0;
      if (raddr[p] != '0) begin
        if (we && (waddr == raddr[p])) begin
          hit[p]   = 1'b1;
          hdata[p] = wdata;
        end
        for (int i = 0; i < DEPTH; i++) begin
          idx = head + PTR_W'(i);
          if ((CNT_W'(i) < count) && (mem[idx].addr == raddr[p])) begin
            hit[p]   = 1'b1;
            hdata[p] = mem[idx].data;
          end
        end
      end
    end
  end

  assign fwd_hit1  = hit[0];
  assign fwd_data1 = hdata[0];
  assign fwd_hit2  = hit[1];
  assign fwd_data2 = hdata[1];

endmodule
